// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - issue/writeback bundle between decode, writeback and the scoreboard
interface regfile_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 2
);
  logic                   i_issue_valid;
  logic [SEL_W-1:0]       i_issue_rs1;
  logic                   i_issue_use_rs1;
  logic [SEL_W-1:0]       i_issue_rs2;
  logic                   i_issue_use_rs2;
  logic [SEL_W-1:0]       i_issue_rd;
  logic                   i_issue_we;
  logic                   o_issue_stall;
  logic                   o_issue_fire;
  logic                   i_wb_valid;
  logic [SEL_W-1:0]       i_wb_rd;
  logic [NUM_REGS-1:0]    o_busy;
  logic [SEL_W+CNT_W-1:0] o_outstanding;
  logic                   o_wb_error;

  // Decode/writeback side drives requests and observes the verdicts.
  modport master (
    output i_issue_valid, i_issue_rs1, i_issue_use_rs1, i_issue_rs2, i_issue_use_rs2,
    output i_issue_rd, i_issue_we, i_wb_valid, i_wb_rd,
    input  o_issue_stall, o_issue_fire, o_busy, o_outstanding, o_wb_error
  );

  // The scoreboard itself.
  modport slave (
    input  i_issue_valid, i_issue_rs1, i_issue_use_rs1, i_issue_rs2, i_issue_use_rs2,
    input  i_issue_rd, i_issue_we, i_wb_valid, i_wb_rd,
    output o_issue_stall, o_issue_fire, o_busy, o_outstanding, o_wb_error
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write counters with RAW/WAW issue stall
module regfile_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int SEL_W       = 4,
  parameter int CNT_W       = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  regfile_scoreboard_if.slave sb
);
  localparam int OW = SEL_W + CNT_W;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    eff_rs1, eff_rs2;
  logic                raw1, raw2, waw, stall, fire;

  // Writeback decrements only registers that actually have a pending write.
  always_comb begin
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec_vec[r] = sb.i_wb_valid && (sb.i_wb_rd == SEL_W'(r)) && (cnt_q[r] != '0);
    end
  end

  // Hazard check: sources see the bypassed writeback, the WAW limit does not.
  always_comb begin
    eff_rs1 = cnt_q[sb.i_issue_rs1] - CNT_W'(dec_vec[sb.i_issue_rs1]);
    eff_rs2 = cnt_q[sb.i_issue_rs2] - CNT_W'(dec_vec[sb.i_issue_rs2]);
    raw1    = sb.i_issue_use_rs1 && (eff_rs1 != '0);
    raw2    = sb.i_issue_use_rs2 && (eff_rs2 != '0);
    waw     = sb.i_issue_we && (cnt_q[sb.i_issue_rd] == CNT_W'(MAX_PENDING));
    stall   = sb.i_issue_valid && (raw1 || raw2 || waw);
    fire    = sb.i_issue_valid && !stall;
  end

  assign sb.o_issue_stall = stall;
  assign sb.o_issue_fire  = fire;

  // Next-state counters, busy image, running total and sticky error.
  always_comb begin
    inc_vec = '0;
    busy_d  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = fire && sb.i_issue_we && (sb.i_issue_rd == SEL_W'(r));
      cnt_d[r]   = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
    outstanding_d = outstanding_q + OW'(|inc_vec) - OW'(|dec_vec);
    err_d         = err_q || (sb.i_wb_valid && (cnt_q[sb.i_wb_rd] == '0));
  end

  // State registers; reset drops all tracking immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign sb.o_busy        = busy_q;
  assign sb.o_outstanding = outstanding_q;
  assign sb.o_wb_error    = err_q;
endmodule
